// File: rtl/fp_mul_arb_if.sv
// -----------------------------------------------------------------------------
// fp_mul_arb_if
// Bundle of the request/grant/result signals shared between the requesters
// and the fp_mul_arb multiplier arbiter.
//   req   : per-requester request, held with stable operands until granted
//   a_in  : packed operand A, requester i in bits [32i+31:32i]
//   b_in  : packed operand B, same packing
//   gnt   : one-hot grant (combinational)
//   vld   : one-hot result-valid pulse (registered)
//   res   : product, meaningful while any vld bit is high
//   busy  : some pipeline stage holds a valid operation
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface fp_mul_arb_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*32-1:0] a_in;
  logic [NUM_REQ*32-1:0] b_in;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    vld;
  logic [31:0]           res;
  logic                  busy;

  modport master (
    output req, a_in, b_in,
    input  gnt, vld, res, busy
  );

  modport slave (
    input  req, a_in, b_in,
    output gnt, vld, res, busy
  );
endinterface

// File: rtl/fp_mul_arb.sv
// -----------------------------------------------------------------------------
// fp_mul_arb
// Round-robin arbiter feeding one shared IEEE-754 single-precision multiplier
// through a two-stage pipeline (operand register, result register).
// A grant in cycle t returns vld/res in cycle t+2; one multiply per cycle.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset, also masks gnt while low
//   arb_bus  : fp_mul_arb_if slave modport (req/a_in/b_in in, gnt/vld/res/busy out)
// -----------------------------------------------------------------------------
module fp_mul_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input logic         clk,
  input logic         rst_n,
  fp_mul_arb_if.slave arb_bus
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  // Truncating single-precision multiply. Denormal inputs use an implicit
  // leading 0 and exponent 1; results below the normal range are shifted into
  // a denormal (truncated) and results above it saturate to infinity.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic               s;
    logic [7:0]         ea;
    logic [7:0]         eb;
    logic [7:0]         ea_eff;
    logic [7:0]         eb_eff;
    logic               a_nan;
    logic               b_nan;
    logic               a_inf;
    logic               b_inf;
    logic               a_zero;
    logic               b_zero;
    logic [23:0]        ma;
    logic [23:0]        mb;
    logic [47:0]        p;
    logic [47:0]        pn;
    logic [5:0]         lead;
    logic signed [11:0] e_n;
    logic [11:0]        sh;
    logic [31:0]        r;
    s      = a[31] ^ b[31];
    ea     = a[30:23];
    eb     = b[30:23];
    a_nan  = (ea == 8'hFF) && (a[22:0] != 23'h0);
    b_nan  = (eb == 8'hFF) && (b[22:0] != 23'h0);
    a_inf  = (ea == 8'hFF) && (a[22:0] == 23'h0);
    b_inf  = (eb == 8'hFF) && (b[22:0] == 23'h0);
    a_zero = (ea == 8'h00) && (a[22:0] == 23'h0);
    b_zero = (eb == 8'h00) && (b[22:0] == 23'h0);
    ea_eff = (ea == 8'h00) ? 8'h01 : ea;
    eb_eff = (eb == 8'h00) ? 8'h01 : eb;
    ma     = {(ea != 8'h00), a[22:0]};
    mb     = {(eb != 8'h00), b[22:0]};
    p      = ma * mb;
    // Locate the leading one so denormal operands normalise correctly.
    lead = 6'd0;
    for (int k = 0; k < 48; k++) begin
      if (p[k]) begin
        lead = 6'(k);
      end else begin
        lead = lead;
      end
    end
    pn  = p << (6'd47 - lead);
    // Product of two 1.x mantissas has its binary point at bit 46.
    e_n = $signed({4'b0000, ea_eff}) + $signed({4'b0000, eb_eff}) - 12'sd127
        + $signed({6'b000000, lead}) - 12'sd46;
    sh  = 12'sd1 - e_n;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      r = {s, 8'hFF, 23'h7FFFFF};
    end else if (a_inf || b_inf) begin
      r = {s, 8'hFF, 23'h000000};
    end else if (a_zero || b_zero) begin
      r = {s, 31'h00000000};
    end else if (e_n >= 12'sd255) begin
      r = {s, 8'hFF, 23'h000000};
    end else if (e_n >= 12'sd1) begin
      r = {s, e_n[7:0], pn[46:24]};
    end else begin
      r = {s, 8'h00, 23'(pn[47:24] >> sh)};
    end
    return r;
  endfunction

  logic [ID_W-1:0]    ptr_q,  ptr_d;
  logic               v1_q,   v1_d;
  logic [ID_W-1:0]    id1_q,  id1_d;
  logic [31:0]        a_q,    a_d;
  logic [31:0]        b_q,    b_d;
  logic [31:0]        res_q,  res_d;
  logic [NUM_REQ-1:0] vld_q,  vld_d;
  logic               busy_q, busy_d;

  logic               found_s;
  logic [ID_W-1:0]    gnt_idx_s;
  logic [31:0]        a_sel_s;
  logic [31:0]        b_sel_s;
  logic [NUM_REQ-1:0] gnt_s;
  int                 scan_idx;

  // Round-robin scan starting at ptr with wrap-around; first hit wins.
  always_comb begin
    found_s   = 1'b0;
    gnt_idx_s = '0;
    a_sel_s   = 32'h0;
    b_sel_s   = 32'h0;
    scan_idx  = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      scan_idx = int'(ptr_q) + off;
      if (scan_idx >= NUM_REQ) begin
        scan_idx = scan_idx - NUM_REQ;
      end else begin
        scan_idx = scan_idx;
      end
      if (!found_s && arb_bus.req[scan_idx]) begin
        found_s   = 1'b1;
        gnt_idx_s = ID_W'(scan_idx);
        a_sel_s   = arb_bus.a_in[scan_idx*32 +: 32];
        b_sel_s   = arb_bus.b_in[scan_idx*32 +: 32];
      end else begin
        found_s   = found_s;
      end
    end
  end

  // One-hot grant, held at zero while reset is asserted.
  always_comb begin
    gnt_s = '0;
    if (found_s && rst_n) begin
      gnt_s[gnt_idx_s] = 1'b1;
    end else begin
      gnt_s = '0;
    end
  end

  // Next-state for pointer and both pipeline stages.
  always_comb begin
    ptr_d  = ptr_q;
    v1_d   = found_s;
    id1_d  = id1_q;
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    vld_d  = '0;
    busy_d = found_s | v1_q;
    if (found_s) begin
      ptr_d = (gnt_idx_s == LAST_ID) ? '0 : gnt_idx_s + ID_W'(1);
      id1_d = gnt_idx_s;
      a_d   = a_sel_s;
      b_d   = b_sel_s;
    end else begin
      ptr_d = ptr_q;
    end
    // vld is decoded one stage early so the output comes straight from a flop.
    if (v1_q) begin
      res_d         = fp_mul(a_q, b_q);
      vld_d[id1_q]  = 1'b1;
    end else begin
      res_d         = res_q;
    end
  end

  // State registers with asynchronous reset discarding in-flight operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      v1_q   <= 1'b0;
      id1_q  <= '0;
      a_q    <= 32'h0;
      b_q    <= 32'h0;
      res_q  <= 32'h0;
      vld_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      v1_q   <= v1_d;
      id1_q  <= id1_d;
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
      vld_q  <= vld_d;
      busy_q <= busy_d;
    end
  end

  assign arb_bus.gnt  = gnt_s;
  assign arb_bus.vld  = vld_q;
  assign arb_bus.res  = res_q;
  assign arb_bus.busy = busy_q;

endmodule

// File: doc/fp_mul_arb.md
# fp_mul_arb

Round-robin arbiter and two-stage pipeline that shares one FP_mul datapath among `NUM_REQ` requesters, such as the neuron MAC lanes of the recognition engine. Each cycle it grants at most one requester, registers that requester's operands, and computes the IEEE-754 single-precision product. One cycle later it registers the product and returns it with a one-hot valid pulse to the requester that issued it. Throughput is one multiply per cycle; latency is fixed at 2 cycles from grant.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the internal requester index.

Ports:
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, `NUM_REQ`: per-requester request; held high with stable operands until granted.
- `a_in`, input, `NUM_REQ*32`: operand A; requester i uses bits [32i+31:32i].
- `b_in`, input, `NUM_REQ*32`: operand B, packed the same way.
- `gnt`, output, `NUM_REQ`: combinational one-hot grant; operands of the granted requester are captured at the end of this cycle.
- `vld`, output, `NUM_REQ`: registered one-hot result-valid pulse, one cycle wide.
- `res`, output, 32: registered product, meaningful only while some `vld` bit is high.
- `busy`, output, 1: high when either pipeline stage holds a valid operation.

## Operation
Arbitration:
- The rotating pointer `ptr` (`ID_W` bits) names the highest-priority requester.
- `gnt` is the first set bit of `req` scanning from `ptr` upward with wrap-around; `gnt` is all zero when `req` is zero.
- On a grant to requester i, `ptr` becomes i+1, wrapping from `NUM_REQ-1` to 0. With no grant, `ptr` is unchanged.

Stage 1 (operand register) loads on the grant edge:
- `a_r` and `b_r` take the granted requester's operands.
- `id1` takes the granted index.
- `v1` is set to 1 if a grant occurred, otherwise 0.

Stage 2 (result register):
- `res` takes FP_mul(`a_r`, `b_r`); `id2` takes `id1`; `v2` takes `v1`.
- When `v1` is 0, `res` holds its previous value.

Outputs:
- `vld` = `v2` ? (1 << `id2`) : 0.
- `busy` = `v1` | `v2`.

Requester behaviour:
- A requester holding `req` high after its grant is treated as issuing a new operation; back-to-back ops from one requester are legal.
- With multiple requesters active, each gets a grant at most every `NUM_REQ` cycles under continuous contention.

Arithmetic is owned entirely by FP_mul, with no rounding beyond its truncation. Special-value encodings come from FP_mul:
- NaN is {S, FF, 7FFFFF}.
- ±Inf is {S, FF, 000000}.
- ±0 is {S, 00, 000000}.
- Denormal outputs pass through unmodified.

Results are never reordered; `vld` order equals grant order.

## Timing
- Reset values (asynchronous on `rst_n` low): `ptr` = 0, `v1` = `v2` = 0, `id1` = `id2` = 0, `a_r` = `b_r` = 0, `res` = 32'h0. Therefore `vld` = 0 and `busy` = 0 during and after reset. `gnt` stays combinational but is forced to 0 while `rst_n` is low.
- Reset mid-operation discards both stages; no `vld` is issued for in-flight ops. A requester whose op was lost must re-request.
- Latency: `gnt` in cycle t gives `vld` and `res` in cycle t+2. A new grant is possible in every cycle with no bubbles.
- Simultaneous events are handled in one cycle: a grant, a stage-1 to stage-2 transfer and a `vld` pulse can all coincide.
- `req` dropped before grant: nothing is captured; `ptr` is unchanged.
- Single requester i holding `req` continuously: granted every cycle, and `ptr` stays at i+1.

## Test plan
- After reset, requester 0 sends `a_in` = 3F800000 and `b_in` = 40000000 (1.0 × 2.0). Required: `gnt` = 0001 in cycle t, then `vld` = 0001 and `res` = 40000000 in cycle t+2; `busy` is high in cycles t+1 and t+2 only.
- Requester 2 sends 40400000 × C0000000 (3.0 × −2.0). Required: `res` = C0C00000 with `vld` = 0100 two cycles after grant.
- Requester 1 sends 7F800000 × 00000000 (+Inf × +0). Required: `res` = 7FFFFFFF (NaN). Requester 3 sends 7F800000 × BF800000 (+Inf × −1.0). Required: `res` = FF800000.
- After reset, all four `req` are held high continuously with distinct operands. Required: `gnt` sequence 0001, 0010, 0100, 1000, 0001. `vld` repeats the same sequence delayed by 2 cycles, and each `res` matches its own operands.
- `ptr` = 2, then `req` = 1011. Required: `gnt` = 1000 and `ptr` becomes 0. Next cycle, with the same `req`: `gnt` = 0001.
- Grant to requester 1 in cycle t, then `rst_n` pulsed low in cycle t+1. Required: no `vld` at any point; `busy` = 0; after release the next grant goes to requester 0 if `req[0]` is high.
